// File: rtl/conv_mac_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_mac_engine_if : valid/ready result stream carrying data + flat index  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface conv_mac_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]  out_index;

  modport master (output out_valid, output out_data, output out_index, input out_ready);
  modport slave  (input out_valid, input out_data, input out_index, output out_ready);
endinterface
`default_nettype wire

// File: rtl/conv_mac_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_mac_engine : sequential 2-D convolution, one MAC per cycle, sat/ReLU  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module conv_mac_engine #(
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ACC_WIDTH    = 2*DATA_WIDTH+8
) (
  input  wire                                                            clk,
  input  wire                                                            rst_n,
  input  wire                                                            start,
  input  wire                                                            relu_en,
  input  wire [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]            input_tensor_flat,
  input  wire [OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_flat,
  input  wire [OUT_CHANNELS*DATA_WIDTH-1:0]                              bias_flat,
  output logic                                                           busy,
  output logic                                                           done,
  conv_mac_engine_if.master                                              out_if
);
  localparam int K          = KERNEL_SIZE;
  localparam int OUT_HEIGHT = (IN_HEIGHT + 2*PADDING - K) / STRIDE + 1;
  localparam int OUT_WIDTH  = (IN_WIDTH  + 2*PADDING - K) / STRIDE + 1;
  localparam int N_OUT      = OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH;
  localparam int IDX_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ICW        = $clog2(IN_CHANNELS + 1);
  localparam int KW         = $clog2(K + 1);
  localparam int OCW        = $clog2(OUT_CHANNELS + 1);
  localparam int OHW        = $clog2(OUT_HEIGHT + 1);
  localparam int OWW        = $clog2(OUT_WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [ACC_WIDTH-1:0] c_sat_max =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_sat_min =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                                               r_state;
  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]     r_x;
  logic [OUT_CHANNELS*IN_CHANNELS*K*K*DATA_WIDTH-1:0]       r_w;
  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                       r_b;
  logic                                                     r_relu;
  logic signed [ACC_WIDTH-1:0]                              r_acc;
  logic [ICW-1:0]                                           r_ic;
  logic [KW-1:0]                                            r_ky;
  logic [KW-1:0]                                            r_kx;
  logic [OCW-1:0]                                           r_oc;
  logic [OHW-1:0]                                           r_oy;
  logic [OWW-1:0]                                           r_ox;
  logic [IDX_W-1:0]                                         r_idx;
  logic [DATA_WIDTH-1:0]                                    r_out_data;

  int                             w_iy;
  int                             w_ix;
  int                             w_xi;
  int                             w_wi;
  logic                           w_in_range;
  logic signed [DATA_WIDTH-1:0]   w_x;
  logic signed [DATA_WIDTH-1:0]   w_w;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_sum;
  logic [DATA_WIDTH-1:0]          w_result;
  logic                           w_kx_wrap;
  logic                           w_ky_wrap;
  logic                           w_ic_wrap;
  logic                           w_last_tap;
  logic                           w_ox_wrap;
  logic                           w_oy_wrap;
  logic                           w_last_out;
  logic [OWW-1:0]                 w_nox;
  logic [OHW-1:0]                 w_noy;
  logic [OCW-1:0]                 w_noc;
  logic [OCW-1:0]                 w_bidx;
  logic [DATA_WIDTH-1:0]          w_bias_raw;
  logic signed [ACC_WIDTH-1:0]    w_bias_next;
  logic signed [ACC_WIDTH-1:0]    w_bias_first;

  // Padding taps select a zero operand but still take their cycle.
  always_comb begin
    w_iy       = int'(r_oy) * STRIDE + int'(r_ky) - PADDING;
    w_ix       = int'(r_ox) * STRIDE + int'(r_kx) - PADDING;
    w_in_range = (w_iy >= 0) && (w_iy < IN_HEIGHT) && (w_ix >= 0) && (w_ix < IN_WIDTH);
    w_xi       = w_in_range ? (int'(r_ic) * IN_HEIGHT + w_iy) * IN_WIDTH + w_ix : 0;
    w_wi       = ((int'(r_oc) * IN_CHANNELS + int'(r_ic)) * K + int'(r_ky)) * K + int'(r_kx);
    w_x        = w_in_range ? r_x[w_xi*DATA_WIDTH +: DATA_WIDTH] : '0;
    w_w        = r_w[w_wi*DATA_WIDTH +: DATA_WIDTH];
    w_prod     = {{DATA_WIDTH{w_x[DATA_WIDTH-1]}}, w_x} * {{DATA_WIDTH{w_w[DATA_WIDTH-1]}}, w_w};
    w_sum      = r_acc + {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

    if (w_sum > c_sat_max)      w_result = c_sat_max[DATA_WIDTH-1:0];
    else if (w_sum < c_sat_min) w_result = c_sat_min[DATA_WIDTH-1:0];
    else                        w_result = w_sum[DATA_WIDTH-1:0];
    if (r_relu && w_result[DATA_WIDTH-1]) w_result = '0;
  end

  always_comb begin
    w_kx_wrap  = (r_kx == KW'(K-1));
    w_ky_wrap  = (r_ky == KW'(K-1));
    w_ic_wrap  = (r_ic == ICW'(IN_CHANNELS-1));
    w_last_tap = w_kx_wrap && w_ky_wrap && w_ic_wrap;
    w_ox_wrap  = (r_ox == OWW'(OUT_WIDTH-1));
    w_oy_wrap  = (r_oy == OHW'(OUT_HEIGHT-1));
    w_last_out = (r_idx == IDX_W'(N_OUT-1));
    w_nox      = w_ox_wrap ? '0 : r_ox + 1'b1;
    w_noy      = w_ox_wrap ? (w_oy_wrap ? '0 : r_oy + 1'b1) : r_oy;
    w_noc      = (w_ox_wrap && w_oy_wrap) ? r_oc + 1'b1 : r_oc;
    w_bidx     = w_last_out ? '0 : w_noc;
    w_bias_raw = r_b[int'(w_bidx)*DATA_WIDTH +: DATA_WIDTH];
    w_bias_next  = {{(ACC_WIDTH-DATA_WIDTH){w_bias_raw[DATA_WIDTH-1]}}, w_bias_raw};
    w_bias_first = {{(ACC_WIDTH-DATA_WIDTH){bias_flat[DATA_WIDTH-1]}}, bias_flat[DATA_WIDTH-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_w        <= '0;
      r_b        <= '0;
      r_relu     <= 1'b0;
      r_acc      <= '0;
      r_ic       <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_oc       <= '0;
      r_oy       <= '0;
      r_ox       <= '0;
      r_idx      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= input_tensor_flat;
            r_w     <= weights_flat;
            r_b     <= bias_flat;
            r_relu  <= relu_en;
            r_acc   <= w_bias_first;
            r_ic    <= '0;
            r_ky    <= '0;
            r_kx    <= '0;
            r_oc    <= '0;
            r_oy    <= '0;
            r_ox    <= '0;
            r_idx   <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          // Tap counters wrap naturally to zero on the last tap.
          r_acc <= w_sum;
          r_kx  <= w_kx_wrap ? '0 : r_kx + 1'b1;
          if (w_kx_wrap) begin
            r_ky <= w_ky_wrap ? '0 : r_ky + 1'b1;
            if (w_ky_wrap) r_ic <= w_ic_wrap ? '0 : r_ic + 1'b1;
          end
          if (w_last_tap) begin
            r_out_data <= w_result;
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_if.out_ready) begin
            if (w_last_out) begin
              r_state <= S_DONE;
            end else begin
              r_ox    <= w_nox;
              r_oy    <= w_noy;
              r_oc    <= w_noc;
              r_idx   <= r_idx + 1'b1;
              r_acc   <= w_bias_next;
              r_state <= S_MAC;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_if.out_valid = (r_state == S_OUT);
  assign out_if.out_data  = r_out_data;
  assign out_if.out_index = r_idx;
  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv_mac_engine : scoreboard bench over three engine configurations     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_conv_mac_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // A: default geometry
  logic          rst_a, start_a, relu_a, busy_a, done_a;
  logic [1023:0] x_a;
  logic [255:0]  w_a;
  logic [31:0]   b_a;
  conv_mac_engine_if #(.DATA_WIDTH(32), .IDX_WIDTH(2)) if_a ();
  conv_mac_engine u_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .relu_en(relu_a),
    .input_tensor_flat(x_a), .weights_flat(w_a), .bias_flat(b_a),
    .busy(busy_a), .done(done_a), .out_if(if_a)
  );

  // B: 2x2 input, K=3, STRIDE=1, PADDING=1
  logic         rst_b, start_b, relu_b, busy_b, done_b;
  logic [127:0] x_b;
  logic [287:0] w_b;
  logic [31:0]  b_b;
  conv_mac_engine_if #(.DATA_WIDTH(32), .IDX_WIDTH(2)) if_b ();
  conv_mac_engine #(
    .IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(2), .IN_WIDTH(2),
    .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .DATA_WIDTH(32)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .relu_en(relu_b),
    .input_tensor_flat(x_b), .weights_flat(w_b), .bias_flat(b_b),
    .busy(busy_b), .done(done_b), .out_if(if_b)
  );

  // C: 8-bit, 1x1 input, K=1 (saturation / ReLU)
  logic       rst_c, start_c, relu_c, busy_c, done_c;
  logic [7:0] x_c, w_c, b_c;
  conv_mac_engine_if #(.DATA_WIDTH(8), .IDX_WIDTH(1)) if_c ();
  conv_mac_engine #(
    .IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(1), .IN_WIDTH(1),
    .KERNEL_SIZE(1), .STRIDE(1), .PADDING(0), .DATA_WIDTH(8)
  ) u_c (
    .clk(clk), .rst_n(rst_c), .start(start_c), .relu_en(relu_c),
    .input_tensor_flat(x_c), .weights_flat(w_c), .bias_flat(b_c),
    .busy(busy_c), .done(done_c), .out_if(if_c)
  );

  int q_a[$], qi_a[$], q_b[$], qi_b[$], q_c[$], qi_c[$];
  int rise_a[$];
  int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
  logic pv_a = 1'b0, pstall_a = 1'b0;
  logic [31:0] pd_a = '0;
  logic [1:0]  pi_a = '0;

  always @(negedge clk) begin
    if (if_a.out_valid && !pv_a) rise_a.push_back(cyc);
    if (pstall_a) begin
      chk("a_hold_valid", if_a.out_valid, 1);
      chk("a_hold_data", if_a.out_data, pd_a);
      chk("a_hold_index", if_a.out_index, pi_a);
    end
    if (if_a.out_valid && if_a.out_ready) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_out data=%0d index=%0d", $signed(if_a.out_data), if_a.out_index);
      end else begin
        chk("a_data", $signed(if_a.out_data), q_a.pop_front());
        chk("a_index", if_a.out_index, qi_a.pop_front());
      end
    end
    if (done_a) done_cnt_a++;
    pv_a     = if_a.out_valid;
    pstall_a = if_a.out_valid && !if_a.out_ready;
    pd_a     = if_a.out_data;
    pi_a     = if_a.out_index;
  end

  always @(negedge clk) begin
    if (if_b.out_valid && if_b.out_ready) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_out data=%0d", $signed(if_b.out_data));
      end else begin
        chk("b_data", $signed(if_b.out_data), q_b.pop_front());
        chk("b_index", if_b.out_index, qi_b.pop_front());
      end
    end
    if (done_b) done_cnt_b++;
  end

  always @(negedge clk) begin
    if (if_c.out_valid && if_c.out_ready) begin
      if (q_c.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_unexpected_out data=%0d", $signed(if_c.out_data));
      end else begin
        chk("c_data", $signed(if_c.out_data), q_c.pop_front());
        chk("c_index", if_c.out_index, qi_c.pop_front());
      end
    end
    if (done_c) done_cnt_c++;
  end

  function automatic logic done_of(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic do_start(input int which, output int t);
    set_start(which, 1'b1);
    cycle();
    set_start(which, 1'b0);
    t = cyc;
  endtask

  task automatic wait_done(input int which, input string name);
    int n = 0;
    while (!done_of(which) && n < 400) begin cycle(); n++; end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s timeout after %0d cycles, required done pulse", name, n);
    end
    cycle();
  endtask

  task automatic load_a();
    for (int i = 0; i < 16; i++) begin
      x_a[i*32 +: 32]      = 32'(i + 1);
      x_a[(16+i)*32 +: 32] = 32'(101 + i);
    end
    for (int i = 0; i < 4; i++) begin
      w_a[i*32 +: 32]     = 32'd1;
      w_a[(4+i)*32 +: 32] = 32'd2;
    end
    b_a = 32'd10;
  endtask

  task automatic push_a();
    int exp_v[4] = '{852, 876, 948, 972};
    for (int i = 0; i < 4; i++) begin q_a.push_back(exp_v[i]); qi_a.push_back(i); end
  endtask

  initial begin
    int t, n, d0;
    rst_a = 0; rst_b = 0; rst_c = 0;
    start_a = 0; start_b = 0; start_c = 0;
    relu_a = 0; relu_b = 0; relu_c = 0;
    x_a = '0; w_a = '0; b_a = '0; x_b = '0; w_b = '0; b_b = '0; x_c = '0; w_c = '0; b_c = '0;
    if_a.out_ready = 1; if_b.out_ready = 1; if_c.out_ready = 1;
    repeat (3) cycle();
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", if_a.out_valid, 0);
    chk("rst_done", done_a, 0);
    chk("rst_data", if_a.out_data, 0);
    chk("rst_index", if_a.out_index, 0);
    chk("rst_b_valid", if_b.out_valid, 0);
    chk("rst_c_busy", busy_c, 0);
    rst_a = 1; rst_b = 1; rst_c = 1;
    cycle();

    // Job A1: timing, plus a start pulse and input corruption while busy
    load_a(); push_a(); rise_a.delete(); d0 = done_cnt_a;
    do_start(0, t);
    chk("a_busy_after_start", busy_a, 1);
    repeat (3) cycle();
    start_a = 1; x_a = ~x_a; b_a = ~b_a;
    cycle();
    start_a = 0;
    wait_done(0, "a1_done");
    chk("a1_num_outputs", rise_a.size(), 4);
    if (rise_a.size() >= 2) begin
      chk("a1_first_latency", rise_a[0] - t, 8);
      chk("a1_period", rise_a[1] - rise_a[0], 9);
    end
    chk("a1_done_pulses", done_cnt_a - d0, 1);
    chk("a1_queue_left", q_a.size(), 0);
    for (int i = 0; i < 3; i++) begin chk("a1_idle_busy", busy_a, 0); cycle(); end

    // Job A2: back-pressure on output 1
    load_a(); push_a(); rise_a.delete(); d0 = done_cnt_a;
    do_start(0, t);
    n = 0;
    while (rise_a.size() < 1 && n < 50) begin cycle(); n++; end
    if_a.out_ready = 0;
    n = 0;
    while (!if_a.out_valid && n < 50) begin cycle(); n++; end
    chk("a2_out1_arrived", if_a.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("a2_stall_valid", if_a.out_valid, 1);
      chk("a2_stall_data", $signed(if_a.out_data), 876);
      chk("a2_stall_index", if_a.out_index, 1);
      cycle();
    end
    if_a.out_ready = 1;
    wait_done(0, "a2_done");
    chk("a2_done_pulses", done_cnt_a - d0, 1);
    chk("a2_queue_left", q_a.size(), 0);

    // Job A3: reset during MAC of output 2, then restart
    push_a();
    do_start(0, t);
    n = 0;
    while (q_a.size() > 2 && n < 100) begin cycle(); n++; end
    chk("a3_two_outputs_seen", q_a.size(), 2);
    repeat (3) cycle();
    rst_a = 0;
    #1;
    chk("a3_rst_busy", busy_a, 0);
    chk("a3_rst_valid", if_a.out_valid, 0);
    chk("a3_rst_done", done_a, 0);
    repeat (2) cycle();
    rst_a = 1;
    q_a.delete(); qi_a.delete();
    for (int i = 0; i < 5; i++) begin chk("a3_no_valid_after_rst", if_a.out_valid, 0); cycle(); end
    load_a(); push_a(); d0 = done_cnt_a;
    do_start(0, t);
    wait_done(0, "a3_restart_done");
    chk("a3_done_pulses", done_cnt_a - d0, 1);
    chk("a3_queue_left", q_a.size(), 0);

    // Job B: padded 3x3 kernel over all-ones 2x2 input
    x_b = {4{32'd1}}; w_b = {9{32'd1}}; b_b = 32'd0;
    for (int i = 0; i < 4; i++) begin q_b.push_back(4); qi_b.push_back(i); end
    d0 = done_cnt_b;
    do_start(1, t);
    wait_done(1, "b_done");
    chk("b_done_pulses", done_cnt_b - d0, 1);
    chk("b_queue_left", q_b.size(), 0);

    // Job C: saturation low, ReLU, saturation high
    x_c = 8'(-100); w_c = 8'd100; b_c = 8'd0; relu_c = 0;
    q_c.push_back(-128); qi_c.push_back(0);
    do_start(2, t);
    wait_done(2, "c1_done");
    relu_c = 1;
    q_c.push_back(0); qi_c.push_back(0);
    do_start(2, t);
    relu_c = 0;
    wait_done(2, "c2_done");
    x_c = 8'd100;
    q_c.push_back(127); qi_c.push_back(0);
    do_start(2, t);
    wait_done(2, "c3_done");
    chk("c_done_pulses", done_cnt_c, 3);
    chk("c_queue_left", q_c.size(), 0);

    repeat (2) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/conv_mac_engine.md
CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

Interface
REQ-001 SHALL have parameter IN_CHANNELS, default 2, input channel count.
REQ-002 SHALL have parameter OUT_CHANNELS, default 1, output channel count.
REQ-003 SHALL have parameters IN_HEIGHT and IN_WIDTH, default 4 each, input spatial size.
REQ-004 SHALL have parameters KERNEL_SIZE 2, STRIDE 2 and PADDING 0, square kernel geometry and symmetric zero padding.
REQ-005 SHALL have parameter DATA_WIDTH, default 32, signed element width.
REQ-006 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+8, signed accumulator width.
REQ-007 SHALL derive OUT_HEIGHT and OUT_WIDTH locally as (IN+2*PADDING-KERNEL_SIZE)/STRIDE+1.
REQ-008 SHALL have a single clock and an asynchronous, active-low reset.
REQ-009 clk  input  1  rising-edge clock.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 start  input  1  job request, sampled in IDLE only.
REQ-012 relu_en  input  1  clamp negative results to 0, sampled with start.
REQ-013 input_tensor_flat  input  IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH  element index ic*IH*IW+iy*IW+ix.
REQ-014 weights_flat  input  OUT_CHANNELS*IN_CHANNELS*K*K*DATA_WIDTH  element index ((oc*IC+ic)*K+ky)*K+kx.
REQ-015 bias_flat  input  OUT_CHANNELS*DATA_WIDTH  element index oc.
REQ-016 busy  output  1  high from the start acceptance until return to IDLE.
REQ-017 out_valid  output  1  out_data and out_index are valid.
REQ-018 out_ready  input  1  consumer accepts the output.
REQ-019 out_data  output  DATA_WIDTH  signed result.
REQ-020 out_index  output  clog2(OUT_CHANNELS*OH*OW)  flat index oc*OH*OW+oy*OW+ox.
REQ-021 done  output  1  single-cycle pulse after the last output handshake.

Function
REQ-022 SHALL implement the states IDLE, MAC, OUT and DONE.
REQ-023 In IDLE with start=1, the block SHALL register all tensors, weights, bias and relu_en, set acc=sign-extended bias[0] and indices to 0, and enter MAC.
REQ-024 start SHALL be ignored outside IDLE, and input changes after acceptance SHALL NOT affect the job.
REQ-025 MAC SHALL accumulate one product per cycle in the order ic, ky, kx (kx fastest), taking N=IN_CHANNELS*K*K cycles per output.
REQ-026 A tap with iy=oy*STRIDE+ky-PADDING or ix outside the input range SHALL contribute 0 and still consume its cycle.
REQ-027 Products SHALL be signed DATA_WIDTH x DATA_WIDTH, sign-extended to ACC_WIDTH, and accumulated without intermediate saturation.
REQ-028 After the Nth tap the block SHALL enter OUT and, on that edge, register out_data = acc saturated to the signed DATA_WIDTH range, then set to 0 if relu_en and the result is negative.
REQ-029 out_valid SHALL be asserted exactly N cycles after the start-acceptance edge.
REQ-030 In OUT, out_valid, out_data and out_index SHALL be held stable until the edge where out_ready=1 (handshake).
REQ-031 On a handshake, ox SHALL advance, then oy, then oc; acc SHALL reload the bias of the new oc and the block SHALL return to MAC.
REQ-032 With out_ready held at 1, the output period SHALL be N+1 cycles.
REQ-033 A handshake on the last output (index OUT_CHANNELS*OH*OW-1) SHALL enter DONE.
REQ-034 DONE SHALL assert done for exactly one cycle, then enter IDLE with busy=0; start is accepted again in the following cycle.
REQ-035 out_valid SHALL be 0 in every state except OUT.

Reset
REQ-036 While rst_n=0, the state SHALL be IDLE and busy, out_valid, done, out_data, out_index, acc and all counters SHALL be 0, applied immediately without waiting for clk.
REQ-037 Reset asserted mid-job SHALL abandon the job, with no further out_valid until a new start.

Verification
REQ-038 The bench SHALL cover the default parameters with channel 0 inputs 1..16, channel 1 inputs 101..116, weights 1 for ch0 and 2 for ch1, bias 10, and out_ready=1. Required response: outputs 852, 876, 948, 972 at indices 0..3, the first out_valid 8 cycles after start, a period of 9 cycles, and one done pulse.
REQ-039 The bench SHALL repeat the REQ-038 stimulus with out_ready low for 5 cycles on output 1. Required response: out_valid=1, out_data=876 and out_index=1 held stable, with no loss or duplication.
REQ-040 The bench SHALL cover IN_CHANNELS=1, a 2x2 input of all 1s, K=3, STRIDE=1, PADDING=1, weights 1 and bias 0. Required response: four outputs, all equal to 4.
REQ-041 The bench SHALL cover DATA_WIDTH=8, a 1x1 input, K=1, x=-100, w=100 and bias 0. Required response: out_data=-128 with relu_en=0, and 0 with relu_en=1; with x=w=100 the response is 127.
REQ-042 The bench SHALL drive rst_n low for 2 cycles during MAC of output 2 in the REQ-038 job. Required response: busy, out_valid and done are 0 at once; a following restart reproduces 852, 876, 948, 972.
REQ-043 The bench SHALL pulse start while busy. Required response: the start is ignored and the current job's results are unchanged.
